// File: rtl/bank_dot_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bank_dot_pkg
// Purpose : Shared types and constants for the bank_dot_master dot-product
//           engine. These are the FSM state encoding, the CSR word offsets,
//           the Q16.16 fraction width and the memory word stride.
// Ports   : none (package)
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
package bank_dot_pkg;

    // Sequencer states. A single element walks RD_W -> WT_W -> RD_I -> WT_I -> MAC.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_W   = 3'd1,
        ST_WT_W   = 3'd2,
        ST_RD_I   = 3'd3,
        ST_WT_I   = 3'd4,
        ST_MAC    = 3'd5,
        ST_WR_OUT = 3'd6
    } state_t;

    // CSR word offsets on the slave port
    localparam logic [2:0] CSR_CTRL   = 3'd0;
    localparam logic [2:0] CSR_RESULT = 3'd1;
    localparam logic [2:0] CSR_WPTR   = 3'd2;
    localparam logic [2:0] CSR_IPTR   = 3'd3;
    localparam logic [2:0] CSR_OPTR   = 3'd4;
    localparam logic [2:0] CSR_LEN    = 3'd5;

    // Q16.16 fixed point
    localparam int FRAC_BITS = 16;

    // Byte distance between consecutive vector words
    localparam int WORD_STRIDE = 4;

endpackage
`default_nettype wire

// File: rtl/bank_dot_master_if.sv
`default_nettype none
// ============================================================================
// Module  : bank_dot_master_if
// Purpose : Bundles the CSR slave port and the memory master port of
//           bank_dot_master.
// Ports   : slave_*  - CSR access from software (address/read/write/data)
//           master_* - Avalon-MM master towards the on-chip RAM banks
// Modports: master - the dot-product engine's view (drives master_* requests
//                    and slave_readdata)
//           slave  - the environment's view (CPU + memory side)
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
interface bank_dot_master_if #(
    parameter int ADDR_W = 32
);
    logic [2:0]        slave_address;
    logic              slave_read;
    logic              slave_write;
    logic [31:0]       slave_writedata;
    logic [31:0]       slave_readdata;

    logic [ADDR_W-1:0] master_address;
    logic              master_read;
    logic              master_write;
    logic [31:0]       master_writedata;
    logic              master_waitrequest;
    logic [31:0]       master_readdata;
    logic              master_readdatavalid;

    modport master (
        input  slave_address, slave_read, slave_write, slave_writedata,
        output slave_readdata,
        output master_address, master_read, master_write, master_writedata,
        input  master_waitrequest, master_readdata, master_readdatavalid
    );

    modport slave (
        output slave_address, slave_read, slave_write, slave_writedata,
        input  slave_readdata,
        input  master_address, master_read, master_write, master_writedata,
        output master_waitrequest, master_readdata, master_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/bank_dot_mac.sv
`default_nettype none
// ============================================================================
// Module  : bank_dot_mac
// Purpose : Registered signed Q16.16 multiply-accumulate. Each enabled cycle
//           adds the Q16.16-aligned slice of a*b to the accumulator with
//           32-bit wraparound and no saturation.
// Ports   : clk, rst_n    - clock, synchronous active-low reset
//           i_clear       - zero the accumulator (wins over i_en)
//           i_en          - accumulate i_a*i_b this cycle
//           i_a, i_b      - signed Q16.16 operands
//           o_acc_next    - accumulator value after an enabled cycle, so the
//                           caller can register the final sum without
//                           waiting a cycle
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
module bank_dot_mac
    import bank_dot_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_clear,
    input  wire logic              i_en,
    input  wire logic [DATA_W-1:0] i_a,
    input  wire logic [DATA_W-1:0] i_b,
    output logic      [DATA_W-1:0] o_acc_next
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic        [DATA_W-1:0]   r_acc;
    logic                       w_unused_prod;

    assign w_prod = $signed(i_a) * $signed(i_b);

    // Keep bits [FRAC_BITS+DATA_W-1:FRAC_BITS]; the rest is dropped by design
    assign o_acc_next    = r_acc + w_prod[FRAC_BITS +: DATA_W];
    assign w_unused_prod = ^{w_prod[2*DATA_W-1:FRAC_BITS+DATA_W], w_prod[FRAC_BITS-1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_acc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bank_dot_master.sv
`default_nettype none
// ============================================================================
// Module  : bank_dot_master
// Purpose : Avalon-MM master computing a Q16.16 dot product of two word
//           vectors in memory. Software programs WPTR/IPTR/OPTR/LEN through
//           the CSR slave port and writes CTRL to start. The block reads
//           weight/input pairs one at a time, accumulates, and writes the sum
//           to OPTR. The sum is also kept in RESULT.
// Ports   : clk   - system clock
//           rst_n - synchronous active-low reset
//           bus   - bank_dot_master_if.master (CSR slave + memory master)
// Options : BANK_DOT_RELU_EN - when defined, a negative sum is written and
//           stored as 0
// Revision: 1.0 - initial release
// ============================================================================
module bank_dot_master
    import bank_dot_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    bank_dot_master_if.master bus
);

    state_t              r_state;

    // Software-visible CSRs
    logic [ADDR_W-1:0]   r_wptr_csr;
    logic [ADDR_W-1:0]   r_iptr_csr;
    logic [ADDR_W-1:0]   r_optr_csr;
    logic [LEN_W-1:0]    r_len_csr;
    logic [DATA_W-1:0]   r_result;

    // Working copies latched at start so CSR traffic cannot disturb a run
    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W-1:0]   r_iptr;
    logic [ADDR_W-1:0]   r_optr;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_weight;
    logic [DATA_W-1:0]   r_input;

    // Set when readdatavalid coincided with request acceptance, so the
    // following wait state already holds its data
    logic                r_data_early;

    logic                w_idle;
    logic                w_start;
    logic                w_mac_clear;
    logic                w_mac_en;
    logic [LEN_W-1:0]    w_idx_inc;
    logic [DATA_W-1:0]   w_acc_next;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [LEN_W-1:0]  idx);
        return base + (ADDR_W'(idx) * ADDR_W'(WORD_STRIDE));
    endfunction

    function automatic logic [DATA_W-1:0] activate(input logic [DATA_W-1:0] v);
`ifdef BANK_DOT_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign w_idle      = (r_state == ST_IDLE);
    assign w_start     = w_idle && bus.slave_write && (bus.slave_address == CSR_CTRL);
    assign w_mac_clear = w_start;
    assign w_mac_en    = (r_state == ST_MAC);
    assign w_idx_inc   = r_idx + 1'b1;

    bank_dot_mac #(
        .DATA_W (DATA_W)
    ) u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_mac_clear),
        .i_en       (w_mac_en),
        .i_a        (r_weight),
        .i_b        (r_input),
        .o_acc_next (w_acc_next)
    );

    // CSR read mux; data is valid in the same cycle as slave_read
    always_comb begin
        bus.slave_readdata = '0;
        if (bus.slave_read) begin
            case (bus.slave_address)
                CSR_CTRL:   bus.slave_readdata = {31'b0, ~w_idle};
                CSR_RESULT: bus.slave_readdata = 32'(r_result);
                CSR_WPTR:   bus.slave_readdata = 32'(r_wptr_csr);
                CSR_IPTR:   bus.slave_readdata = 32'(r_iptr_csr);
                CSR_OPTR:   bus.slave_readdata = 32'(r_optr_csr);
                CSR_LEN:    bus.slave_readdata = 32'(r_len_csr);
                default:    bus.slave_readdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state              <= ST_IDLE;
            r_wptr_csr           <= '0;
            r_iptr_csr           <= '0;
            r_optr_csr           <= '0;
            r_len_csr            <= '0;
            r_result             <= '0;
            r_wptr               <= '0;
            r_iptr               <= '0;
            r_optr               <= '0;
            r_len                <= '0;
            r_idx                <= '0;
            r_weight             <= '0;
            r_input              <= '0;
            r_data_early         <= 1'b0;
            bus.master_address   <= '0;
            bus.master_read      <= 1'b0;
            bus.master_write     <= 1'b0;
            bus.master_writedata <= '0;
        end else begin
            // Configuration writes land only while idle
            if (w_idle && bus.slave_write) begin
                case (bus.slave_address)
                    CSR_WPTR: r_wptr_csr <= ADDR_W'(bus.slave_writedata);
                    CSR_IPTR: r_iptr_csr <= ADDR_W'(bus.slave_writedata);
                    CSR_OPTR: r_optr_csr <= ADDR_W'(bus.slave_writedata);
                    CSR_LEN:  r_len_csr  <= bus.slave_writedata[LEN_W-1:0];
                    default: ;
                endcase
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_wptr       <= r_wptr_csr;
                        r_iptr       <= r_iptr_csr;
                        r_optr       <= r_optr_csr;
                        r_len        <= r_len_csr;
                        r_idx        <= '0;
                        r_data_early <= 1'b0;
                        if (r_len_csr != '0) begin
                            r_state            <= ST_RD_W;
                            bus.master_read    <= 1'b1;
                            bus.master_address <= r_wptr_csr;
                        end else begin
                            // Empty vector: the sum is zero, go straight to the write
                            r_state              <= ST_WR_OUT;
                            bus.master_write     <= 1'b1;
                            bus.master_address   <= r_optr_csr;
                            bus.master_writedata <= 32'(activate('0));
                        end
                    end
                end

                ST_RD_W: begin
                    if (!bus.master_waitrequest) begin
                        bus.master_read <= 1'b0;
                        r_state         <= ST_WT_W;
                        if (bus.master_readdatavalid) begin
                            r_weight     <= DATA_W'(bus.master_readdata);
                            r_data_early <= 1'b1;
                        end
                    end
                end

                ST_WT_W: begin
                    if (r_data_early || bus.master_readdatavalid) begin
                        if (!r_data_early) begin
                            r_weight <= DATA_W'(bus.master_readdata);
                        end
                        r_data_early       <= 1'b0;
                        r_state            <= ST_RD_I;
                        bus.master_read    <= 1'b1;
                        bus.master_address <= word_addr(r_iptr, r_idx);
                    end
                end

                ST_RD_I: begin
                    if (!bus.master_waitrequest) begin
                        bus.master_read <= 1'b0;
                        r_state         <= ST_WT_I;
                        if (bus.master_readdatavalid) begin
                            r_input      <= DATA_W'(bus.master_readdata);
                            r_data_early <= 1'b1;
                        end
                    end
                end

                ST_WT_I: begin
                    if (r_data_early || bus.master_readdatavalid) begin
                        if (!r_data_early) begin
                            r_input <= DATA_W'(bus.master_readdata);
                        end
                        r_data_early <= 1'b0;
                        r_state      <= ST_MAC;
                    end
                end

                ST_MAC: begin
                    // The accumulator updates on this same edge; w_acc_next is the final sum
                    r_idx <= w_idx_inc;
                    if (w_idx_inc == r_len) begin
                        r_state              <= ST_WR_OUT;
                        bus.master_write     <= 1'b1;
                        bus.master_address   <= r_optr;
                        bus.master_writedata <= 32'(activate(w_acc_next));
                    end else begin
                        r_state            <= ST_RD_W;
                        bus.master_read    <= 1'b1;
                        bus.master_address <= word_addr(r_wptr, w_idx_inc);
                    end
                end

                ST_WR_OUT: begin
                    if (!bus.master_waitrequest) begin
                        bus.master_write <= 1'b0;
                        r_result         <= DATA_W'(bus.master_writedata);
                        r_state          <= ST_IDLE;
                    end
                end

                default: begin
                    r_state         <= ST_IDLE;
                    bus.master_read  <= 1'b0;
                    bus.master_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bank_dot_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_bank_dot_master
// Purpose : Self-checking bench for bank_dot_master. A memory responder with
//           programmable waitrequest and readdatavalid latency checks every
//           accepted read/write against a scoreboard of expected addresses
//           and data filled in when each run is started.
// Options : BANK_DOT_RELU_EN - expected sums follow the ReLU behaviour
// Revision: 1.0 - initial release
// ============================================================================
module tb_bank_dot_master;
    import bank_dot_pkg::*;

    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bank_dot_master_if #(.ADDR_W(ADDR_W)) bus ();

    bank_dot_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (32),
        .LEN_W  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks      = 0;
    int failures    = 0;
    int wait_cycles = 0;
    int rdv_delay   = 0;
    int rd_accepts  = 0;
    int wr_count    = 0;

    logic [31:0]       mem [logic [31:0]];
    logic [ADDR_W-1:0] exp_rd_q[$];
    logic [ADDR_W-1:0] exp_wr_addr_q[$];
    logic [31:0]       exp_wr_data_q[$];
    logic [31:0]       vec_w [8];
    logic [31:0]       vec_i [8];
    logic [31:0]       exp_result;

    // ---------------- memory responder + scoreboard consumer ----------------
    initial begin : responder
        int                stall_cnt;
        bit                prev_stalled;
        logic [ADDR_W-1:0] held_addr;
        logic              held_rd;
        logic              held_wr;
        bit                rd_pending;
        int                rd_cnt;
        logic [31:0]       rd_data;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] ea;
        logic [31:0]       ed;
        stall_cnt    = 0;
        prev_stalled = 0;
        held_addr    = '0;
        held_rd      = 0;
        held_wr      = 0;
        rd_pending   = 0;
        rd_cnt       = 0;
        rd_data      = '0;
        bus.master_waitrequest   = 1'b0;
        bus.master_readdata      = '0;
        bus.master_readdatavalid = 1'b0;
        forever begin
            @(negedge clk);
            bus.master_readdatavalid = 1'b0;
            if (!rst_n) begin
                prev_stalled = 0;
                stall_cnt    = 0;
            end
            if (rd_pending) begin
                if (rd_cnt == 0) begin
                    bus.master_readdatavalid = 1'b1;
                    bus.master_readdata      = rd_data;
                    rd_pending               = 0;
                end else begin
                    rd_cnt--;
                end
            end
            if (prev_stalled) begin
                checks++;
                if (bus.master_address !== held_addr || bus.master_read !== held_rd ||
                    bus.master_write !== held_wr) begin
                    failures++;
                    $display("FAIL hold_stable: addr=%h rd=%b wr=%b, required addr=%h rd=%b wr=%b",
                             bus.master_address, bus.master_read, bus.master_write,
                             held_addr, held_rd, held_wr);
                end
            end
            if (rst_n && (bus.master_read === 1'b1 || bus.master_write === 1'b1)) begin
                if (stall_cnt < wait_cycles) begin
                    bus.master_waitrequest = 1'b1;
                    stall_cnt++;
                    prev_stalled = 1;
                    held_addr    = bus.master_address;
                    held_rd      = bus.master_read;
                    held_wr      = bus.master_write;
                end else begin
                    bus.master_waitrequest = 1'b0;
                    stall_cnt    = 0;
                    prev_stalled = 0;
                    a = bus.master_address;
                    if (bus.master_read) begin
                        rd_accepts++;
                        checks++;
                        if (exp_rd_q.size() == 0) begin
                            failures++;
                            $display("FAIL read_addr: unexpected read at %h, required no read", a);
                        end else begin
                            ea = exp_rd_q.pop_front();
                            if (a !== ea) begin
                                failures++;
                                $display("FAIL read_addr: got %h, required %h", a, ea);
                            end
                        end
                        rd_data = mem.exists(a) ? mem[a] : 32'h0;
                        if (rdv_delay == 0) begin
                            bus.master_readdatavalid = 1'b1;
                            bus.master_readdata      = rd_data;
                        end else begin
                            rd_pending = 1;
                            rd_cnt     = rdv_delay - 1;
                        end
                    end else begin
                        wr_count++;
                        checks++;
                        if (exp_wr_addr_q.size() == 0) begin
                            failures++;
                            $display("FAIL write: unexpected write %h to %h, required no write",
                                     bus.master_writedata, a);
                        end else begin
                            ea = exp_wr_addr_q.pop_front();
                            ed = exp_wr_data_q.pop_front();
                            if (a !== ea || bus.master_writedata !== ed) begin
                                failures++;
                                $display("FAIL write: got %h to %h, required %h to %h",
                                         bus.master_writedata, a, ed, ea);
                            end
                        end
                    end
                end
            end else begin
                bus.master_waitrequest = 1'b0;
                prev_stalled = 0;
            end
        end
    end

    // ---------------- CSR access ----------------
    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.slave_address   = a;
        bus.slave_writedata = d;
        bus.slave_write     = 1'b1;
        @(negedge clk);
        bus.slave_write     = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.slave_address = a;
        bus.slave_read    = 1'b1;
        #1;
        d = bus.slave_readdata;
        bus.slave_read    = 1'b0;
    endtask

    // Loads memory, fills the scoreboard from a reference model, programs and starts
    task automatic start_run(input logic [31:0] wptr, input logic [31:0] iptr,
                             input logic [31:0] optr, input int len);
        logic signed [63:0] p;
        logic [31:0]        acc;
        exp_rd_q.delete();
        exp_wr_addr_q.delete();
        exp_wr_data_q.delete();
        acc = '0;
        for (int k = 0; k < len; k++) begin
            mem[wptr + 32'(4 * k)] = vec_w[k];
            mem[iptr + 32'(4 * k)] = vec_i[k];
            exp_rd_q.push_back(wptr + 32'(4 * k));
            exp_rd_q.push_back(iptr + 32'(4 * k));
            p   = $signed(vec_w[k]) * $signed(vec_i[k]);
            acc = acc + p[47:16];
        end
`ifdef BANK_DOT_RELU_EN
        if (acc[31]) acc = '0;
`endif
        exp_result = acc;
        exp_wr_addr_q.push_back(optr);
        exp_wr_data_q.push_back(acc);
        csr_write(CSR_WPTR, wptr);
        csr_write(CSR_IPTR, iptr);
        csr_write(CSR_OPTR, optr);
        csr_write(CSR_LEN, 32'(len));
        csr_write(CSR_CTRL, 32'h1);
    endtask

    task automatic finish_run(input string name);
        logic [31:0] d;
        bit          done;
        done = 0;
        for (int c = 0; c < 400; c++) begin
            csr_read(CSR_CTRL, d);
            if (d[0] == 1'b0) begin
                done = 1;
                break;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout: busy still %b after 400 polls, required 0", name, d[0]);
        end
        csr_read(CSR_RESULT, d);
        checks++;
        if (d !== exp_result) begin
            failures++;
            $display("FAIL %s_result: got %h, required %h", name, d, exp_result);
        end
        checks++;
        if (exp_rd_q.size() != 0 || exp_wr_addr_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: reads left %0d writes left %0d, required 0 and 0",
                     name, exp_rd_q.size(), exp_wr_addr_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        bus.slave_address   = '0;
        bus.slave_read      = 1'b0;
        bus.slave_write     = 1'b0;
        bus.slave_writedata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.master_read !== 1'b0 || bus.master_write !== 1'b0 ||
            bus.master_address !== '0 || bus.master_writedata !== '0 ||
            bus.slave_readdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs: rd=%b wr=%b addr=%h wdata=%h rdata=%h, required all 0",
                     bus.master_read, bus.master_write, bus.master_address,
                     bus.master_writedata, bus.slave_readdata);
        end
        rst_n = 1'b1;
        csr_read(CSR_CTRL, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_ctrl: got %h, required 00000000", d);
        end
        csr_read(CSR_RESULT, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_result: got %h, required 00000000", d);
        end
    endtask

    task automatic test_csr();
        logic [31:0] d;
        csr_write(3'd6, 32'hFFFF_FFFF);
        csr_read(3'd6, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL csr_off6: got %h, required 00000000", d);
        end
        csr_read(3'd7, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL csr_off7: got %h, required 00000000", d);
        end
        csr_write(CSR_WPTR, 32'h1234_5678);
        csr_read(CSR_WPTR, d);
        checks++;
        if (d !== 32'h1234_5678) begin
            failures++;
            $display("FAIL csr_wptr: got %h, required 12345678", d);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        wait_cycles = 0;
        rdv_delay   = 0;
        vec_w[0] = 32'h0001_0000; vec_i[0] = 32'h0002_0000;
        vec_w[1] = 32'h0001_0000; vec_i[1] = 32'h0003_0000;
        start_run(32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 2);
        csr_read(CSR_CTRL, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("FAIL basic_busy: got %h, required 00000001", d);
        end
        finish_run("basic");
        csr_read(CSR_RESULT, d);
        checks++;
        if (d !== 32'h0005_0000) begin
            failures++;
            $display("FAIL basic_const: got %h, required 00050000", d);
        end
    endtask

    task automatic test_negative();
        logic [31:0] d;
        logic [31:0] want;
        wait_cycles = 0;
        rdv_delay   = 1;
        vec_w[0] = 32'hFFFE_8000; vec_i[0] = 32'h0002_0000;
        start_run(32'h0000_1100, 32'h0000_2100, 32'h0000_3100, 1);
        finish_run("negative");
`ifdef BANK_DOT_RELU_EN
        want = 32'h0000_0000;
`else
        want = 32'hFFFD_0000;
`endif
        csr_read(CSR_RESULT, d);
        checks++;
        if (d !== want) begin
            failures++;
            $display("FAIL negative_const: got %h, required %h", d, want);
        end
    endtask

    task automatic test_len_zero();
        int rd0;
        int wr0;
        rd0 = rd_accepts;
        wr0 = wr_count;
        wait_cycles = 0;
        rdv_delay   = 0;
        start_run(32'h0000_1200, 32'h0000_2200, 32'h0000_3200, 0);
        finish_run("len_zero");
        checks++;
        if (rd_accepts != rd0 || wr_count != wr0 + 1) begin
            failures++;
            $display("FAIL len_zero_traffic: reads %0d writes %0d, required 0 and 1",
                     rd_accepts - rd0, wr_count - wr0);
        end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        wait_cycles = 3;
        rdv_delay   = 2;
        vec_w[0] = 32'h0001_0000; vec_i[0] = 32'h0002_0000;
        vec_w[1] = 32'h0001_0000; vec_i[1] = 32'h0003_0000;
        // Weight pointer straddles the top of the address space
        start_run(32'hFFFF_FFFC, 32'h0000_2000, 32'h0000_3300, 2);
        finish_run("stall");
        csr_read(CSR_RESULT, d);
        checks++;
        if (d !== 32'h0005_0000) begin
            failures++;
            $display("FAIL stall_const: got %h, required 00050000", d);
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        int          target;
        bit          hit;
        wait_cycles = 0;
        rdv_delay   = 3;
        vec_w[0] = 32'h0001_0000; vec_i[0] = 32'h0002_0000;
        vec_w[1] = 32'h0001_0000; vec_i[1] = 32'h0003_0000;
        target = rd_accepts + 4;
        start_run(32'h0000_1400, 32'h0000_2400, 32'h0000_3400, 2);
        hit = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rd_accepts >= target) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL midrun_reach: reads %0d, required %0d", rd_accepts, target);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (bus.master_read !== 1'b0 || bus.master_write !== 1'b0 || bus.master_address !== '0) begin
            failures++;
            $display("FAIL midrun_outputs: rd=%b wr=%b addr=%h, required 0 0 0",
                     bus.master_read, bus.master_write, bus.master_address);
        end
        csr_read(CSR_CTRL, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL midrun_busy: got %h, required 00000000", d);
        end
        csr_read(CSR_RESULT, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL midrun_result_clr: got %h, required 00000000", d);
        end
        vec_w[0] = 32'h0003_0000; vec_i[0] = 32'h0000_8000;
        start_run(32'h0000_1500, 32'h0000_2500, 32'h0000_3500, 1);
        finish_run("after_reset");
        csr_read(CSR_RESULT, d);
        checks++;
        if (d !== 32'h0001_8000) begin
            failures++;
            $display("FAIL after_reset_const: got %h, required 00018000", d);
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] d;
        int          rd0;
        int          wr0;
        rd0 = rd_accepts;
        wr0 = wr_count;
        wait_cycles = 3;
        rdv_delay   = 2;
        vec_w[0] = 32'h0001_0000; vec_i[0] = 32'h0002_0000;
        vec_w[1] = 32'h0001_0000; vec_i[1] = 32'h0003_0000;
        start_run(32'h0000_1600, 32'h0000_2600, 32'h0000_3600, 2);
        csr_write(CSR_LEN, 32'd7);
        csr_write(CSR_CTRL, 32'h1);
        finish_run("busy_ignore");
        csr_read(CSR_LEN, d);
        checks++;
        if (d !== 32'd2) begin
            failures++;
            $display("FAIL busy_ignore_len: got %h, required 00000002", d);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (rd_accepts != rd0 + 4 || wr_count != wr0 + 1) begin
            failures++;
            $display("FAIL busy_ignore_traffic: reads %0d writes %0d, required 4 and 1",
                     rd_accepts - rd0, wr_count - wr0);
        end
    endtask

    initial begin
        test_reset();
        test_csr();
        test_basic();
        test_negative();
        test_len_zero();
        test_stall();
        test_reset_midrun();
        test_busy_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
